// File: rtl/tomasula_types_pkg.sv
// Types and constants shared by the Tomasulo execute-side blocks.
package tomasula_types;

  localparam int CDB_TAG_W   = 3;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_NUM_REQ = 5;

  localparam int RS1  = 0;
  localparam int RS2  = 1;
  localparam int RS3  = 2;
  localparam int RS4  = 3;
  localparam int RSBR = 4;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: searches ptr+1, ptr+2, ... modulo N.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin owner of the common data bus: grants one result per cycle and
// broadcasts the winner's tag/data on a registered CDB one cycle later.
module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      cdb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam logic [SRC_W-1:0] PTR_INIT = SRC_W'(NUM_REQ - 1);

  logic [SRC_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pick;
  logic [SRC_W-1:0]   win_idx;
  logic               win_any;
  logic               grant_en;
  logic [TAG_W-1:0]   win_tag;
  logic [DATA_W-1:0]  win_data;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (SRC_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (pick),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  // Gating by rst_n keeps acks quiet while reset is held, not just after an edge.
  assign grant_en = rst_n && !flush && !cdb_stall && win_any;
  assign req_ack  = grant_en ? pick : '0;
  assign win_tag  = req_tag[int'(win_idx)*TAG_W +: TAG_W];
  assign win_data = req_data[int'(win_idx)*DATA_W +: DATA_W];

  // Stage p0 -> p1: pointer update and CDB broadcast register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= PTR_INIT;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      ptr       <= PTR_INIT;
      cdb_valid <= 1'b0;
    end else if (!cdb_stall) begin
      if (grant_en) begin
        ptr       <= win_idx;
        cdb_valid <= 1'b1;
        cdb_tag   <= win_tag;
        cdb_data  <= win_data;
        cdb_src   <= win_idx;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus multi-cycle corner sequences.
module tb_cdb_arbiter;
  localparam int N  = 5;
  localparam int TW = 3;
  localparam int DW = 32;
  localparam int SW = 3;
  localparam logic [31:0] DBASE = 32'hC0DE_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          cdb_stall = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ack;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [SW-1:0] cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cdb_stall (cdb_stall),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic         fl;
    logic         st;
    logic [4:0]   rv;
    logic [4:0]   ack;
    logic         vld;
    logic [2:0]   src;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic default_payload();
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = TW'(i);
      req_data[i*DW +: DW] = DBASE + 32'(i);
    end
  endtask

  task automatic drive(input logic fl, input logic st, input logic [4:0] rv);
    @(negedge clk);
    flush = fl;
    cdb_stall = st;
    req_valid = rv;
    #1;
  endtask

  task automatic settle_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 5'h1F, 5'h01, 1'b1, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 5'h1F, 5'h02, 1'b1, 3'd1};
    vecs[2]  = '{1'b0, 1'b0, 5'h1F, 5'h04, 1'b1, 3'd2};
    vecs[3]  = '{1'b0, 1'b0, 5'h1F, 5'h08, 1'b1, 3'd3};
    vecs[4]  = '{1'b0, 1'b0, 5'h1F, 5'h10, 1'b1, 3'd4};
    vecs[5]  = '{1'b0, 1'b0, 5'h1F, 5'h01, 1'b1, 3'd0};
    vecs[6]  = '{1'b0, 1'b0, 5'h1F, 5'h02, 1'b1, 3'd1};
    vecs[7]  = '{1'b0, 1'b0, 5'h1F, 5'h04, 1'b1, 3'd2};
    vecs[8]  = '{1'b0, 1'b0, 5'h1F, 5'h08, 1'b1, 3'd3};
    vecs[9]  = '{1'b0, 1'b0, 5'h1F, 5'h10, 1'b1, 3'd4};
    vecs[10] = '{1'b0, 1'b0, 5'h08, 5'h08, 1'b1, 3'd3};
    vecs[11] = '{1'b0, 1'b0, 5'h05, 5'h01, 1'b1, 3'd0};
    vecs[12] = '{1'b0, 1'b0, 5'h05, 5'h04, 1'b1, 3'd2};
    vecs[13] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 3'd2};
    vecs[14] = '{1'b0, 1'b1, 5'h02, 5'h00, 1'b0, 3'd2};
    vecs[15] = '{1'b1, 1'b0, 5'h10, 5'h00, 1'b0, 3'd2};
    vecs[16] = '{1'b0, 1'b0, 5'h11, 5'h01, 1'b1, 3'd0};
    vecs[17] = '{1'b0, 1'b0, 5'h1F, 5'h02, 1'b1, 3'd1};
    vecs[18] = '{1'b1, 1'b1, 5'h1F, 5'h00, 1'b0, 3'd1};
    vecs[19] = '{1'b0, 1'b0, 5'h1F, 5'h01, 1'b1, 3'd0};
    vecs[20] = '{1'b0, 1'b0, 5'h04, 5'h04, 1'b1, 3'd2};
    vecs[21] = '{1'b0, 1'b1, 5'h1F, 5'h00, 1'b1, 3'd2};
    vecs[22] = '{1'b0, 1'b1, 5'h1F, 5'h00, 1'b1, 3'd2};
    vecs[23] = '{1'b0, 1'b0, 5'h1F, 5'h08, 1'b1, 3'd3};
    vecs[24] = '{1'b0, 1'b0, 5'h1F, 5'h10, 1'b1, 3'd4};
    vecs[25] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 3'd4};

    default_payload();

    // Reset held: outputs cleared and no ack even with every request pending
    req_valid = 5'h1F;
    #12;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("rst_cdb_data", 64'(cdb_data), 64'd0);
    chk("rst_cdb_src", 64'(cdb_src), 64'd0);
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    for (int v = 0; v < 26; v++) begin
      drive(vecs[v].fl, vecs[v].st, vecs[v].rv);
      chk($sformatf("vec%0d_ack", v), 64'(req_ack), 64'(vecs[v].ack));
      settle_edge();
      chk($sformatf("vec%0d_valid", v), 64'(cdb_valid), 64'(vecs[v].vld));
      chk($sformatf("vec%0d_tag", v), 64'(cdb_tag), 64'(vecs[v].src));
      chk($sformatf("vec%0d_data", v), 64'(cdb_data), 64'(DBASE + 32'(vecs[v].src)));
      chk($sformatf("vec%0d_src", v), 64'(cdb_src), 64'(vecs[v].src));
    end

    // Stall holds a live broadcast for three cycles, then the waiter wins
    req_tag[2*TW +: TW]  = 3'd2;
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    drive(1'b0, 1'b0, 5'b00100);
    chk("stall_pre_ack", 64'(req_ack), 64'h04);
    settle_edge();
    chk("stall_pre_tag", 64'(cdb_tag), 64'd2);
    chk("stall_pre_data", 64'(cdb_data), 64'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 5'b00010);
      chk($sformatf("stall%0d_ack", c), 64'(req_ack), 64'h0);
      settle_edge();
      chk($sformatf("stall%0d_valid", c), 64'(cdb_valid), 64'd1);
      chk($sformatf("stall%0d_tag", c), 64'(cdb_tag), 64'd2);
      chk($sformatf("stall%0d_data", c), 64'(cdb_data), 64'hDEADBEEF);
      chk($sformatf("stall%0d_src", c), 64'(cdb_src), 64'd2);
    end
    drive(1'b0, 1'b0, 5'b00010);
    chk("stall_release_ack", 64'(req_ack), 64'h02);
    settle_edge();
    chk("stall_release_src", 64'(cdb_src), 64'd1);
    default_payload();

    // Single requester (branch station) streams three results back to back
    for (int t = 1; t <= 3; t++) begin
      req_tag[4*TW +: TW]  = TW'(t);
      req_data[4*DW +: DW] = 32'h0000_B000 + 32'(t);
      drive(1'b0, 1'b0, 5'b10000);
      chk($sformatf("stream%0d_ack", t), 64'(req_ack), 64'h10);
      settle_edge();
      chk($sformatf("stream%0d_valid", t), 64'(cdb_valid), 64'd1);
      chk($sformatf("stream%0d_tag", t), 64'(cdb_tag), 64'(t));
      chk($sformatf("stream%0d_data", t), 64'(cdb_data), 64'(32'h0000_B000 + 32'(t)));
      chk($sformatf("stream%0d_src", t), 64'(cdb_src), 64'd4);
    end
    default_payload();

    // Asynchronous reset while a broadcast is on the bus
    req_valid = 5'h1F;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_tag", 64'(cdb_tag), 64'd0);
    chk("async_rst_ack", 64'(req_ack), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ack", 64'(req_ack), 64'h01);
    settle_edge();
    chk("post_rst_valid", 64'(cdb_valid), 64'd1);
    chk("post_rst_src", 64'(cdb_src), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) among the execute-side requesters: the four ALU reservation stations and the branch reservation station. Each cycle it grants the bus to one pending result using rotating (round-robin) priority. It acknowledges the winner and broadcasts that winner's ROB tag and data on a registered CDB, one cycle later, to the ROB, the regfile and all reservation stations. The arbiter sits between the functional-unit outputs and the ROB/reservation-station snoop logic.

Parameters:
NUM_REQ, 5, number of requesters (index 0-3 = res1-res4, index 4 = resbr)
TAG_W, 3, ROB tag width
DATA_W, 32, result data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  branch-mispredict flush; discards pending grant and broadcast
cdb_stall  in  1  consumer (ROB) cannot accept a broadcast this cycle
req_valid  in  NUM_REQ  per-requester result pending
req_tag  in  NUM_REQ*TAG_W  per-requester ROB tag, requester i at [i*TAG_W +: TAG_W]
req_data  in  NUM_REQ*DATA_W  per-requester result, requester i at [i*DATA_W +: DATA_W]
req_ack  out  NUM_REQ  one-hot grant; requester drops/advances its result on ack
cdb_valid  out  1  broadcast valid
cdb_tag  out  TAG_W  broadcast ROB tag
cdb_data  out  DATA_W  broadcast value
cdb_src  out  $clog2(NUM_REQ)  index of the requester that owns the current broadcast

Behaviour:
- Reset (async, rst_n low): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0. Priority pointer ptr=NUM_REQ-1, so requester 0 has first priority. req_ack=0 while in reset.
- Requesters hold req_valid, req_tag and req_data stable until acked. The arbiter never acks a requester whose req_valid is low.
- Grant (combinational):
  - Condition: flush=0, cdb_stall=0 and req_valid!=0.
  - Winner: the first i with req_valid[i]=1, searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - req_ack is one-hot on the winner; otherwise req_ack=0.
- Pointer: on any cycle with a grant, ptr <= winner on the clock edge. ptr is otherwise unchanged.
- Broadcast (registered, latency 1): on the edge after a grant, cdb_valid=1, cdb_tag=req_tag[winner], cdb_data=req_data[winner], cdb_src=winner.
- No grant, not stalled: cdb_valid <= 0 on the next edge. cdb_tag, cdb_data and cdb_src hold their old values.
- cdb_stall=1: no grant, and all cdb_* outputs hold, including cdb_valid. A broadcast stays visible until the first cycle in which cdb_stall=0, and is consumed in that cycle.
- flush=1:
  - req_ack=0 that cycle.
  - cdb_valid <= 0 on the next edge, regardless of cdb_stall.
  - ptr <= NUM_REQ-1.
  - flush overrides grant and stall.
- Fairness: with all requesters continuously valid and no stall or flush, each requester is acked exactly once in every NUM_REQ consecutive grants.
- Simultaneous case: a requester may raise a new req_valid in the same cycle it is acked only as a new result on the following cycle. The arbiter treats each cycle's inputs independently.
- Wrap-around: if ptr=NUM_REQ-1, the search starts at index 0.
- Single requester: the same requester may win on consecutive cycles, giving back-to-back broadcasts of different results.

Decomposition:
- Shared package tomasula_types:
  - add cdb_t, a packed struct {tag[TAG_W-1:0], data[DATA_W-1:0]};
  - add localparam CDB_NUM_REQ=5;
  - add the requester index constants RS1..RS4=0..3 and RSBR=4.
- Sub-module rr_arbiter #(N): purely combinational rotating-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: grant one-hot, grant_idx, any.
- cdb_arbiter owns the pointer register, the stall/flush gating and the broadcast registers.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-broadcast (cdb_valid=1) -> cdb_valid=0 and req_ack=0 immediately (asynchronous). After release, req_valid=5'b11111 -> first ack=5'b00001.
- Round-robin: hold req_valid=5'b11111 for 10 cycles, each requester's tag=i -> ack sequence 0,1,2,3,4,0,1,2,3,4. cdb_tag follows one cycle later, with cdb_valid=1 throughout.
- Sparse requests with wrap: ptr=3 (last winner 3), req_valid=5'b00101 -> ack=5'b00001 (search 4,0). Next cycle, same requests -> ack=5'b00100.
- Stall: broadcast tag=2/data=32'hDEADBEEF, then cdb_stall=1 for 3 cycles with req_valid=5'b00010 -> req_ack=0 and cdb outputs unchanged for 3 cycles. First cycle after stall drops -> ack=5'b00010.
- Flush: req_valid=5'b10000 with flush=1 -> req_ack=0, cdb_valid=0 on next edge, ptr reset. Next cycle, req_valid=5'b10001 -> ack=5'b00001.
- Single requester streaming: requester 4 presents tags 1,2,3 back-to-back, each dropped on ack -> three consecutive acks to index 4, and cdb_tag=1,2,3 on consecutive cycles.
